fsm_line_sequencer: RTL and testbench

Line-level controller for the bottle filling and sealing cell. It runs the conveyor, opens the fill valve for a fixed time, and hands each filled bottle to the sealer FSM through `lleno_flag` and `productook`. It then waits for the sealer's completion and counts bottles toward a batch. It sits above the sealer FSM on the same 1 Hz clock domain and drives the cell's actuator and status LEDs.

---
 rtl/fsm_line_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_fsm_line_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fsm_line_sequencer.sv
// fsm_line_sequencer
// Line-level controller for the bottle filling and sealing cell. Runs the
// conveyor, opens the fill valve for a fixed time, hands each filled bottle to
// the sealer FSM (lleno_flag pulse + productook level), waits for the sealer's
// completion and counts sealed bottles toward a batch. Actuator and status
// outputs are decoded from the state register; bottle_count is its own register.

module fsm_line_sequencer #(
    parameter int FILL_CYCLES  = 3,
    parameter int MOVE_TIMEOUT = 8,
    parameter int SEAL_TIMEOUT = 6,
    parameter int BATCH_SIZE   = 10,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             bottle_present,
    input  logic             seal_done,
    output logic             conveyor_on,
    output logic             valve_open,
    output logic             lleno_flag,
    output logic             productook,
    output logic             batch_done,
    output logic             fault,
    output logic [CNT_W-1:0] bottle_count,
    output logic [2:0]       state_indicator
);

    // ------------------------------------------------------------------
    // State encoding: the numeric codes are visible on state_indicator.
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADVANCE   = 3'd1,
        ST_FILL      = 3'd2,
        ST_HANDOFF   = 3'd3,
        ST_WAIT_SEAL = 3'd4,
        ST_BATCH_END = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    localparam int NUM_STATES = 7;

    // The timer only ever needs to reach the longest limit minus one, since
    // every limit is acted upon in the cycle where the timer shows limit-1.
    localparam int T_MAX_AB = (MOVE_TIMEOUT > SEAL_TIMEOUT) ? MOVE_TIMEOUT : SEAL_TIMEOUT;
    localparam int T_MAX    = (T_MAX_AB > FILL_CYCLES) ? T_MAX_AB : FILL_CYCLES;
    localparam int TW       = (T_MAX < 2) ? 1 : $clog2(T_MAX + 1);

    localparam logic [TW-1:0]    MOVE_LAST  = TW'(MOVE_TIMEOUT - 1);
    localparam logic [TW-1:0]    SEAL_LAST  = TW'(SEAL_TIMEOUT - 1);
    localparam logic [TW-1:0]    FILL_LAST  = TW'(FILL_CYCLES - 1);
    localparam logic [TW-1:0]    TIMER_TOP  = TW'(T_MAX);
    localparam logic [CNT_W-1:0] BATCH_CNT  = CNT_W'(BATCH_SIZE);

    state_t            state_reg;
    state_t            state_next;
    logic [TW-1:0]     timer_reg;
    logic [TW-1:0]     timer_next;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W-1:0]  count_inc;
    logic              stop_pending_reg;
    logic              stop_pending_next;
    logic              go_req;
    logic              timed_state;
    logic              bottle_phase;
    logic [NUM_STATES-1:0] state_hot;

    // A production request is honoured only when stop is not also asserted.
    assign go_req = start & ~stop;

    // Saturating increment keeps the count from ever passing the batch size.
    assign count_inc = (count_reg >= BATCH_CNT) ? count_reg : (count_reg + 1'b1);

    // ------------------------------------------------------------------
    // One-hot view of the state register used by the output decode.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_state_hot
            assign state_hot[gi] = (state_reg == state_t'(gi));
        end
    endgenerate

    // States in which the cycle timer advances.
    assign timed_state  = state_hot[ST_ADVANCE] | state_hot[ST_FILL] | state_hot[ST_WAIT_SEAL];

    // States belonging to an in-flight bottle, where a stop is deferred.
    assign bottle_phase = state_hot[ST_FILL] | state_hot[ST_HANDOFF] | state_hot[ST_WAIT_SEAL];

    // State register, cycle timer, batch counter and deferred-stop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            timer_reg        <= '0;
            count_reg        <= '0;
            stop_pending_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            timer_reg        <= timer_next;
            count_reg        <= count_next;
            stop_pending_reg <= stop_pending_next;
        end
    end

    // Next-state and counter-update logic.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            ST_IDLE: begin
                if (go_req) begin
                    state_next = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                // A bottle arriving on the last allowed cycle still wins.
                if (bottle_present) begin
                    state_next = ST_FILL;
                end else if (stop) begin
                    state_next = ST_IDLE;
                end else if (timer_reg == MOVE_LAST) begin
                    state_next = ST_FAULT;
                end
            end
            ST_FILL: begin
                // Losing the bottle under an open valve is always a fault.
                if (!bottle_present) begin
                    state_next = ST_FAULT;
                end else if (timer_reg == FILL_LAST) begin
                    state_next = ST_HANDOFF;
                end
            end
            ST_HANDOFF: begin
                state_next = ST_WAIT_SEAL;
            end
            ST_WAIT_SEAL: begin
                if (seal_done) begin
                    count_next = count_inc;
                    if (count_inc == BATCH_CNT) begin
                        state_next = ST_BATCH_END;
                    end else if (stop_pending_reg || stop) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_ADVANCE;
                    end
                end else if (timer_reg == SEAL_LAST) begin
                    state_next = ST_FAULT;
                end
            end
            ST_BATCH_END: begin
                if (go_req) begin
                    state_next = ST_ADVANCE;
                    count_next = '0;
                end
            end
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Timer restarts on every state change and otherwise counts the cycles
    // spent in a timed state; it saturates rather than wrapping.
    always_comb begin
        timer_next = timer_reg;
        if (state_next != state_reg) begin
            timer_next = '0;
        end else if (timed_state && (timer_reg != TIMER_TOP)) begin
            timer_next = timer_reg + 1'b1;
        end
    end

    // Deferred stop: remembered during a bottle's cycle, forgotten on reaching IDLE.
    always_comb begin
        stop_pending_next = stop_pending_reg;
        if (state_next == ST_IDLE) begin
            stop_pending_next = 1'b0;
        end else if (stop && bottle_phase) begin
            stop_pending_next = 1'b1;
        end
    end

    // Moore output decode from the state register.
    always_comb begin
        conveyor_on     = state_hot[ST_ADVANCE];
        valve_open      = state_hot[ST_FILL];
        lleno_flag      = state_hot[ST_HANDOFF];
        productook      = state_hot[ST_HANDOFF] | state_hot[ST_WAIT_SEAL];
        batch_done      = state_hot[ST_BATCH_END];
        fault           = state_hot[ST_FAULT];
        state_indicator = state_reg;
    end

    assign bottle_count = count_reg;

endmodule

// File: tb/tb_fsm_line_sequencer.sv
// Directed testbench for fsm_line_sequencer: a linear sequence of steps with
// hand-computed expected outputs, checked one cycle at a time.

module tb_fsm_line_sequencer;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             bottle_present;
    logic             seal_done;
    logic             conveyor_on;
    logic             valve_open;
    logic             lleno_flag;
    logic             productook;
    logic             batch_done;
    logic             fault;
    logic [CNT_W-1:0] bottle_count;
    logic [2:0]       state_indicator;

    int vectors;
    int miscompares;

    fsm_line_sequencer #(
        .FILL_CYCLES  (3),
        .MOVE_TIMEOUT (8),
        .SEAL_TIMEOUT (6),
        .BATCH_SIZE   (3),
        .CNT_W        (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .stop            (stop),
        .bottle_present  (bottle_present),
        .seal_done       (seal_done),
        .conveyor_on     (conveyor_on),
        .valve_open      (valve_open),
        .lleno_flag      (lleno_flag),
        .productook      (productook),
        .batch_done      (batch_done),
        .fault           (fault),
        .bottle_count    (bottle_count),
        .state_indicator (state_indicator)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle before sampling.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output: state, conveyor, valve, lleno, productook, batch, fault, count.
    task automatic expect_out(input string tag, input logic [2:0] st, input logic cv,
                              input logic vo, input logic lf, input logic pt,
                              input logic bd, input logic ft, input int cnt);
        chk({tag, ".flags"},
            {23'd0, state_indicator, conveyor_on, valve_open, lleno_flag, productook, batch_done, fault},
            {23'd0, st, cv, vo, lf, pt, bd, ft});
        chk({tag, ".count"}, {24'd0, bottle_count}, cnt);
        $display("step %-14s state=%0d conv=%b valve=%b lleno=%b took=%b batch=%b fault=%b count=%0d",
                 tag, state_indicator, conveyor_on, valve_open, lleno_flag, productook,
                 batch_done, fault, bottle_count);
    endtask

    // One bottle from ADVANCE: fill 3 cycles, handoff, seal after seal_wait WAIT_SEAL cycles.
    task automatic run_bottle(input string tag, input int seal_wait, input int cnt_before,
                              input logic [2:0] st_after, input logic bd_after);
        bottle_present = 1'b1;
        cyc(); expect_out({tag, ".fill1"}, 3'd2, 0, 1, 0, 0, 0, 0, cnt_before);
        cyc(); expect_out({tag, ".fill2"}, 3'd2, 0, 1, 0, 0, 0, 0, cnt_before);
        cyc(); expect_out({tag, ".fill3"}, 3'd2, 0, 1, 0, 0, 0, 0, cnt_before);
        cyc(); expect_out({tag, ".handoff"}, 3'd3, 0, 0, 1, 1, 0, 0, cnt_before);
        bottle_present = 1'b0;
        cyc(); expect_out({tag, ".wait1"}, 3'd4, 0, 0, 0, 1, 0, 0, cnt_before);
        for (int i = 1; i < seal_wait; i++) begin
            cyc(); expect_out({tag, ".waitn"}, 3'd4, 0, 0, 0, 1, 0, 0, cnt_before);
        end
        seal_done = 1'b1;
        cyc();
        seal_done = 1'b0;
        expect_out({tag, ".sealed"}, st_after, st_after == 3'd1, 0, 0, 0, bd_after, 0, cnt_before + 1);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst            = 1'b1;
        start          = 1'b0;
        stop           = 1'b0;
        bottle_present = 1'b0;
        seal_done      = 1'b0;

        // Reset state
        cyc(); cyc();
        expect_out("reset", 3'd0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // start together with stop: stop wins
        start = 1'b1; stop = 1'b1;
        cyc(); expect_out("start_stop", 3'd0, 0, 0, 0, 0, 0, 0, 0);
        stop = 1'b0;

        // Nominal bottle: two ADVANCE cycles, then bottle, seal 2 cycles after lleno
        cyc(); expect_out("nom.adv1", 3'd1, 1, 0, 0, 0, 0, 0, 0);
        start = 1'b0;
        cyc(); expect_out("nom.adv2", 3'd1, 1, 0, 0, 0, 0, 0, 0);
        run_bottle("nom", 2, 0, 3'd1, 1'b0);

        // Batch: two more bottles complete the batch of three
        run_bottle("b2", 2, 1, 3'd1, 1'b0);
        seal_done = 1'b1;   // ignored outside WAIT_SEAL
        run_bottle("b3", 1, 2, 3'd5, 1'b1);
        bottle_present = 1'b1;   // ignored in BATCH_END
        cyc(); expect_out("batch.hold", 3'd5, 0, 0, 0, 0, 1, 0, 3);
        bottle_present = 1'b0;
        start = 1'b1;
        cyc(); expect_out("batch.restart", 3'd1, 1, 0, 0, 0, 0, 0, 0);
        start = 1'b0;

        // Graceful stop pulsed during FILL: bottle completes, then IDLE
        bottle_present = 1'b1;
        cyc(); expect_out("gs.fill1", 3'd2, 0, 1, 0, 0, 0, 0, 0);
        stop = 1'b1;
        cyc(); expect_out("gs.fill2", 3'd2, 0, 1, 0, 0, 0, 0, 0);
        stop = 1'b0;
        cyc(); expect_out("gs.fill3", 3'd2, 0, 1, 0, 0, 0, 0, 0);
        cyc(); expect_out("gs.handoff", 3'd3, 0, 0, 1, 1, 0, 0, 0);
        bottle_present = 1'b0;
        cyc(); expect_out("gs.wait1", 3'd4, 0, 0, 0, 1, 0, 0, 0);
        seal_done = 1'b1;
        cyc(); expect_out("gs.idle", 3'd0, 0, 0, 0, 0, 0, 0, 1);
        seal_done = 1'b0;

        // Seal timeout: 6 WAIT_SEAL cycles without seal_done, count unchanged
        start = 1'b1;
        cyc(); expect_out("st.adv", 3'd1, 1, 0, 0, 0, 0, 0, 1);
        start = 1'b0;
        bottle_present = 1'b1;
        cyc(); cyc(); cyc();
        expect_out("st.fill3", 3'd2, 0, 1, 0, 0, 0, 0, 1);
        cyc(); expect_out("st.handoff", 3'd3, 0, 0, 1, 1, 0, 0, 1);
        bottle_present = 1'b0;
        cyc(); expect_out("st.wait1", 3'd4, 0, 0, 0, 1, 0, 0, 1);
        for (int i = 2; i <= 6; i++) begin
            cyc(); expect_out("st.waitn", 3'd4, 0, 0, 0, 1, 0, 0, 1);
        end
        cyc(); expect_out("st.fault", 3'd6, 0, 0, 0, 0, 0, 1, 1);

        // Move timeout: 8 ADVANCE cycles without a bottle, fault held despite start
        rst = 1'b1;
        cyc(); expect_out("mt.reset", 3'd0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        start = 1'b1;
        cyc(); expect_out("mt.adv1", 3'd1, 1, 0, 0, 0, 0, 0, 0);
        start = 1'b0;
        for (int i = 2; i <= 8; i++) begin
            cyc(); expect_out("mt.advn", 3'd1, 1, 0, 0, 0, 0, 0, 0);
        end
        cyc(); expect_out("mt.fault", 3'd6, 0, 0, 0, 0, 0, 1, 0);
        start = 1'b1;
        cyc(); expect_out("mt.hold", 3'd6, 0, 0, 0, 0, 0, 1, 0);
        start = 1'b0;

        // Bottle on the 8th ADVANCE cycle wins over the timeout; then removed mid-FILL
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        start = 1'b1;
        cyc(); expect_out("b8.adv1", 3'd1, 1, 0, 0, 0, 0, 0, 0);
        start = 1'b0;
        for (int i = 2; i <= 8; i++) begin
            cyc();
        end
        expect_out("b8.adv8", 3'd1, 1, 0, 0, 0, 0, 0, 0);
        bottle_present = 1'b1;
        cyc(); expect_out("b8.fill", 3'd2, 0, 1, 0, 0, 0, 0, 0);
        bottle_present = 1'b0;
        cyc(); expect_out("rm.fault", 3'd6, 0, 0, 0, 0, 0, 1, 0);

        // Reset mid-FILL with a nonzero count
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        run_bottle("rf", 1, 0, 3'd1, 1'b0);
        bottle_present = 1'b1;
        cyc(); cyc();
        expect_out("rf.fill2", 3'd2, 0, 1, 0, 0, 0, 0, 1);
        rst = 1'b1;
        cyc(); expect_out("rf.reset", 3'd0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        bottle_present = 1'b0;
        cyc(); expect_out("rf.idle", 3'd0, 0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
